gravity_board: RTL

GRAVITY_BOARD -- requirements
Module: gravity_board

---
 rtl/board_pkg.sv | 8 +
 rtl/gravity_col_ctr.sv | 22 ++
 rtl/gravity_board.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// board_pkg: shared cell/state encodings and player-to-cell mapping for the gravity board.
package board_pkg;
  typedef enum logic [1:0] {EMPTY = 2'b00, P0 = 2'b01, P1 = 2'b10} cell_t;
  typedef enum logic [1:0] {IDLE, DROP, CLEAR} state_t;
  function automatic cell_t player_cell(input logic p);
    return p ? P1 : P0;
  endfunction
endpackage

// File: rtl/gravity_col_ctr.sv
// gravity_col_ctr: per-column piece count 0..ROWS with increment, clear and full flag.
// Ports: clk, rst_n (async active-low), inc_i (add one piece), clr_i (zero count),
//        height_o (pieces in column), full_o (column holds ROWS pieces).
module gravity_col_ctr #(
  parameter int ROWS = 6,
  localparam int HW = $clog2(ROWS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [HW-1:0] height_o,
  output logic          full_o
);
  logic [HW-1:0] height_q, height_d;
  assign full_o = height_q == HW'(ROWS);
  assign height_o = height_q;
  assign height_d = clr_i ? '0 : (inc_i && !full_o) ? height_q + 1'b1 : height_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) height_q <= '0;
    else height_q <= height_d;
endmodule

// File: rtl/gravity_board.sv
// gravity_board: ROWSxCOLS drop-style game board with per-column gravity, row reads and staged clear.
// Ports: clk, rst_n (async active-low);
//        drop_valid/drop_col/drop_player -> drop_ready, drop_done/drop_err/drop_row (result pulse);
//        rd_en/rd_row -> rd_valid/rd_data (one-cycle read, column c at bits [2c+1:2c]);
//        clear (wipe board); col_full/board_full (decoded from column heights).
module gravity_board
  import board_pkg::*;
#(
  parameter int ROWS = 6,
  parameter int COLS = 7,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              drop_valid,
  input  logic [CW-1:0]     drop_col,
  input  logic              drop_player,
  output logic              drop_ready,
  output logic              drop_done,
  output logic              drop_err,
  output logic [RW-1:0]     drop_row,
  input  logic              rd_en,
  input  logic [RW-1:0]     rd_row,
  output logic              rd_valid,
  output logic [2*COLS-1:0] rd_data,
  input  logic              clear,
  output logic [COLS-1:0]   col_full,
  output logic              board_full
);
  localparam int HW = $clog2(ROWS + 1);
  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic player_q, player_d, pend_q, pend_d;
  logic [RW-1:0] crow_q, crow_d, row_q, row_d;
  logic [ROWS-1:0][2*COLS-1:0] board_q, board_d;
  logic done_q, done_d, err_q, err_d, rdv_q;
  logic [2*COLS-1:0] rdd_q;
  logic [COLS-1:0][HW-1:0] height;
  logic [HW-1:0] sel_h;
  logic sel_full, col_ok, do_inc, do_clr;
  always_comb begin
    sel_h = '0;
    sel_full = 1'b0;
    for (int c = 0; c < COLS; c++)
      if (col_q == CW'(c)) begin
        sel_h = height[c];
        sel_full = col_full[c];
      end
  end
  // Out-of-range columns leave sel_full low, so the range test must be explicit.
  assign col_ok = (int'(col_q) < COLS) && !sel_full;
  assign do_inc = state_q == DROP && col_ok;
  // Heights drop to zero on the clear-accept edge; cells are wiped row by row afterwards.
  assign do_clr = state_q == IDLE && (clear || pend_q);
  for (genvar c = 0; c < COLS; c++) begin : g_col
    gravity_col_ctr #(.ROWS(ROWS)) u_ctr (
      .clk(clk),
      .rst_n(rst_n),
      .inc_i(do_inc && col_q == CW'(c)),
      .clr_i(do_clr),
      .height_o(height[c]),
      .full_o(col_full[c])
    );
  end
  assign board_full = &col_full;
  // A pending clear will win over any drop, so hold off the handshake until it runs.
  assign drop_ready = state_q == IDLE && !pend_q;
  assign drop_done = done_q;
  assign drop_err = err_q;
  assign drop_row = row_q;
  assign rd_valid = rdv_q;
  assign rd_data = rdd_q;
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    player_d = player_q;
    pend_d = pend_q;
    crow_d = crow_q;
    board_d = board_q;
    done_d = 1'b0;
    err_d = 1'b0;
    row_d = row_q;
    case (state_q)
      IDLE:
        if (do_clr) begin
          state_d = CLEAR;
          crow_d = '0;
          pend_d = 1'b0;
        end else if (drop_valid) begin
          state_d = DROP;
          col_d = drop_col;
          player_d = drop_player;
        end
      DROP: begin
        state_d = IDLE;
        pend_d = pend_q | clear;
        done_d = 1'b1;
        err_d = !col_ok;
        if (col_ok) begin
          row_d = RW'(sel_h);
          for (int c = 0; c < COLS; c++)
            if (col_q == CW'(c)) board_d[RW'(sel_h)][2*c+:2] = player_cell(player_q);
        end
      end
      CLEAR: begin
        board_d[crow_q] = '0;
        state_d = crow_q == RW'(ROWS - 1) ? IDLE : CLEAR;
        crow_d = crow_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      col_q <= '0;
      player_q <= 1'b0;
      pend_q <= 1'b0;
      crow_q <= '0;
      board_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      row_q <= '0;
      rdv_q <= 1'b0;
      rdd_q <= '0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      player_q <= player_d;
      pend_q <= pend_d;
      crow_q <= crow_d;
      board_q <= board_d;
      done_q <= done_d;
      err_q <= err_d;
      row_q <= row_d;
      rdv_q <= rd_en;
      if (rd_en) rdd_q <= (int'(rd_row) < ROWS) ? board_q[rd_row] : '0;
    end
endmodule
